// File: rtl/sram_pkg.sv
// Shared types and default sizes for the SoC SRAM port 0 arbiter.
package sram_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 11;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic                  we;
        logic [NUM_WMASKS-1:0] be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant generator: round-robin on contention, or fixed m0 priority
// when SRAM_ARB_FIXED_PRIO_EN is defined. Grants are suppressed during reset.
module rr_arb2 (
`ifndef SRAM_ARB_FIXED_PRIO_EN
    input  logic       clk,
`endif
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import sram_pkg::*;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // NOTE: gnt gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end
`else
    req_id_e last;

    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req == 2'b11) begin
                // The master that did not win last time takes the contended slot.
                gnt = (last == REQ_M1) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= REQ_M1;
        end else if (gnt[0]) begin
            last <= REQ_M0;
        end else if (gnt[1]) begin
            last <= REQ_M1;
        end
    end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port 0 between m0 (fetch) and m1 (load/store); routes the
// one-cycle-latency response back. SRAM_ARB_FIXED_PRIO_EN selects fixed m0 priority.
module sram_port_arbiter #(
    parameter int NUM_WMASKS = sram_pkg::NUM_WMASKS,
    parameter int DATA_WIDTH = sram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = sram_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req,
    output logic                  m0_gnt,
    input  logic                  m0_we,
    input  logic [NUM_WMASKS-1:0] m0_be,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    output logic                  m1_gnt,
    input  logic                  m1_we,
    input  logic [NUM_WMASKS-1:0] m1_be,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);
    import sram_pkg::*;

    logic [1:0] gnt;
    logic       granted;
    logic       win_we;
    req_id_e    win_id;

    logic       rsp_vld;
    req_id_e    rsp_id;
    logic       rsp_we;

    rr_arb2 u_arb (
`ifndef SRAM_ARB_FIXED_PRIO_EN
        .clk   (clk),
`endif
        .rst_n (rst_n),
        .req   ({m1_req, m0_req}),
        .gnt   (gnt)
    );

    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];
    assign granted = |gnt;
    assign win_id  = gnt[1] ? REQ_M1 : REQ_M0;
    assign win_we  = gnt[1] ? m1_we : m0_we;

    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (gnt[0]) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~m0_we;
            sram_wmask0 = m0_be;
            sram_addr0  = m0_addr;
            sram_din0   = m0_wdata;
        end else if (gnt[1]) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~m1_we;
            sram_wmask0 = m1_be;
            sram_addr0  = m1_addr;
            sram_din0   = m1_wdata;
        end
    end

    // Tracks the access issued last cycle; its data arrives on sram_dout0 now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld <= 1'b0;
            rsp_id  <= REQ_M0;
            rsp_we  <= 1'b0;
        end else begin
            rsp_vld <= granted;
            if (granted) begin
                rsp_id <= win_id;
                rsp_we <= win_we;
            end
        end
    end

    assign m0_rvalid = rsp_vld && (rsp_id == REQ_M0);
    assign m1_rvalid = rsp_vld && (rsp_id == REQ_M1);
    assign m0_rdata  = (m0_rvalid && !rsp_we) ? sram_dout0 : '0;
    assign m1_rdata  = (m1_rvalid && !rsp_we) ? sram_dout0 : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed vector table, reset and
// withdraw sequences, then randomized traffic against a transaction-level model.
module tb_sram_port_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int BW    = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mst_t;

    typedef struct {
        mst_t          s0;
        mst_t          s1;
        logic [1:0]    exp_gnt;   // {m1, m0}
        logic [1:0]    exp_rv;    // {m1, m0}
        logic [DW-1:0] exp_rdata;
    } vec_t;

    localparam mst_t IDLE = '0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_gnt, m0_we, m0_rvalid;
    logic [BW-1:0] m0_be;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_gnt, m1_we, m1_rvalid;
    logic [BW-1:0] m1_be;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          sram_csb0, sram_web0;
    logic [BW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .NUM_WMASKS (BW),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_req      (m0_req),
        .m0_gnt      (m0_gnt),
        .m0_we       (m0_we),
        .m0_be       (m0_be),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_gnt      (m1_gnt),
        .m1_we       (m1_we),
        .m1_be       (m1_be),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < BW; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
        return (old_w & ~m) | (new_w & m);
    endfunction

    // Behavioural single-port SRAM with one-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= merge(mem[sram_addr0], sram_din0, sram_wmask0);
            else            sram_dout0      <= mem[sram_addr0];
        end
    end

    // Transaction-level reference: who owns the fairness token, what the
    // outstanding response should carry, and the memory contents it implies.
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_last = 1;
    bit            m_vld  = 1'b0;
    int            m_id   = 0;
    bit            m_we   = 1'b0;
    logic [DW-1:0] m_data = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic mst_t rd(input logic [AW-1:0] a);
        mst_t s;
        s = '0;
        s.req  = 1'b1;
        s.addr = a;
        return s;
    endfunction

    function automatic mst_t wr(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        mst_t s;
        s.req   = 1'b1;
        s.we    = 1'b1;
        s.be    = be;
        s.addr  = a;
        s.wdata = d;
        return s;
    endfunction

    function automatic mst_t rnd_mst();
        mst_t s;
        s.req   = ($urandom_range(0, 2) != 0);
        s.we    = 1'($urandom_range(0, 1));
        s.be    = BW'($urandom);
        s.addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                              : AW'(DEPTH - 8 + $urandom_range(0, 7));
        s.wdata = $urandom;
        return s;
    endfunction

    // One clock: drive at the falling edge, check 1 ns later, advance the model.
    task automatic step(input string tag, input logic rst, input mst_t s0, input mst_t s1, output int win);
        mst_t sel;
        bit   fixed;
        @(negedge clk);
        rst_n    = rst;
        m0_req   = s0.req;  m0_we = s0.we;  m0_be = s0.be;  m0_addr = s0.addr;  m0_wdata = s0.wdata;
        m1_req   = s1.req;  m1_we = s1.we;  m1_be = s1.be;  m1_addr = s1.addr;  m1_wdata = s1.wdata;
        #1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        fixed = 1'b1;
`else
        fixed = 1'b0;
`endif
        if (!rst) begin
            m_last = 1;
            m_vld  = 1'b0;
        end
        if (!rst)                 win = -1;
        else if (s0.req && s1.req) win = (fixed || m_last == 1) ? 0 : 1;
        else if (s0.req)          win = 0;
        else if (s1.req)          win = 1;
        else                      win = -1;
        sel = (win == 1) ? s1 : s0;

        check({tag, " gnt0"},  32'(m0_gnt),    32'(win == 0));
        check({tag, " gnt1"},  32'(m1_gnt),    32'(win == 1));
        check({tag, " csb0"},  32'(sram_csb0), 32'(win < 0));
        check({tag, " web0"},  32'(sram_web0), (win < 0) ? 32'd1 : 32'(!sel.we));
        check({tag, " wmask"}, 32'(sram_wmask0), (win < 0) ? 32'd0 : 32'(sel.be));
        check({tag, " addr"},  32'(sram_addr0),  (win < 0) ? 32'd0 : 32'(sel.addr));
        check({tag, " din"},   sram_din0,        (win < 0) ? 32'd0 : sel.wdata);
        check({tag, " rvalid0"}, 32'(m0_rvalid), 32'(m_vld && m_id == 0));
        check({tag, " rvalid1"}, 32'(m1_rvalid), 32'(m_vld && m_id == 1));
        check({tag, " rdata0"},  m0_rdata, (m_vld && m_id == 0 && !m_we) ? m_data : 32'd0);
        check({tag, " rdata1"},  m1_rdata, (m_vld && m_id == 1 && !m_we) ? m_data : 32'd0);

        if (win >= 0) begin
            m_vld  = 1'b1;
            m_id   = win;
            m_we   = sel.we;
            m_data = ref_mem[sel.addr];
            if (sel.we) ref_mem[sel.addr] = merge(ref_mem[sel.addr], sel.wdata, sel.be);
            m_last = win;
        end else begin
            m_vld = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("TB watchdog expired before completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        mst_t r0, r1;
        int   win;
        logic rs;

        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_be = '0; m1_addr = '0; m1_wdata = '0;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DW'(i) * 32'h9E37_79B1;
            ref_mem[i] = DW'(i) * 32'h9E37_79B1;
        end
        mem[11'h005] = 32'hDEAD_BEEF;  ref_mem[11'h005] = 32'hDEAD_BEEF;
        mem[11'h010] = 32'hA5A5_0010;  ref_mem[11'h010] = 32'hA5A5_0010;
        mem[11'h011] = 32'h5A5A_0011;  ref_mem[11'h011] = 32'h5A5A_0011;
        mem[11'h020] = 32'hC0DE_0020;  ref_mem[11'h020] = 32'hC0DE_0020;
        mem[11'h7FF] = 32'h0000_0000;  ref_mem[11'h7FF] = 32'h0000_0000;

        for (int i = 0; i < 3; i++) step($sformatf("reset%0d", i), 1'b0, IDLE, IDLE, win);
        for (int i = 0; i < 10; i++) step($sformatf("idle%0d", i), 1'b1, IDLE, IDLE, win);

        // Directed table: single read, masked write/read, contention, withdrawn request.
        tbl.push_back('{rd(11'h005), IDLE,                                    2'b01, 2'b00, 32'h0});
        tbl.push_back('{IDLE,        IDLE,                                    2'b00, 2'b01, 32'hDEAD_BEEF});
        tbl.push_back('{IDLE,        wr(11'h7FF, 4'b0101, 32'h1122_3344),     2'b10, 2'b00, 32'h0});
        tbl.push_back('{IDLE,        rd(11'h7FF),                             2'b10, 2'b10, 32'h0});
        tbl.push_back('{rd(11'h010), rd(11'h011),                             2'b01, 2'b10, 32'h0022_0044});
`ifdef SRAM_ARB_FIXED_PRIO_EN
        tbl.push_back('{rd(11'h010), rd(11'h011),                             2'b01, 2'b01, 32'hA5A5_0010});
        tbl.push_back('{rd(11'h010), rd(11'h011),                             2'b01, 2'b01, 32'hA5A5_0010});
        tbl.push_back('{rd(11'h010), rd(11'h011),                             2'b01, 2'b01, 32'hA5A5_0010});
        tbl.push_back('{IDLE,        IDLE,                                    2'b00, 2'b01, 32'hA5A5_0010});
`else
        tbl.push_back('{rd(11'h010), rd(11'h011),                             2'b10, 2'b01, 32'hA5A5_0010});
        tbl.push_back('{rd(11'h010), rd(11'h011),                             2'b01, 2'b10, 32'h5A5A_0011});
        tbl.push_back('{rd(11'h010), rd(11'h011),                             2'b10, 2'b01, 32'hA5A5_0010});
        tbl.push_back('{IDLE,        IDLE,                                    2'b00, 2'b10, 32'h5A5A_0011});
`endif
        tbl.push_back('{rd(11'h020), rd(11'h021),                             2'b01, 2'b00, 32'h0});
        tbl.push_back('{IDLE,        IDLE,                                    2'b00, 2'b01, 32'hC0DE_0020});
        tbl.push_back('{IDLE,        IDLE,                                    2'b00, 2'b00, 32'h0});

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), 1'b1, tbl[i].s0, tbl[i].s1, win);
            check($sformatf("vec%0d tbl_gnt", i),    32'({m1_gnt, m0_gnt}),       32'(tbl[i].exp_gnt));
            check($sformatf("vec%0d tbl_rvalid", i), 32'({m1_rvalid, m0_rvalid}), 32'(tbl[i].exp_rv));
            check($sformatf("vec%0d tbl_rdata0", i), m0_rdata, tbl[i].exp_rv[0] ? tbl[i].exp_rdata : 32'h0);
            check($sformatf("vec%0d tbl_rdata1", i), m1_rdata, tbl[i].exp_rv[1] ? tbl[i].exp_rdata : 32'h0);
        end

        // Reset lands while an m0 read response is pending; it must be dropped
        // and the fairness token must return to favouring m0.
        step("rst_seq0", 1'b1, rd(11'h005), IDLE, win);
        check("rst_seq pre_gnt0", 32'(m0_gnt), 32'd1);
        step("rst_seq1", 1'b0, rd(11'h005), rd(11'h006), win);
        check("rst_seq hold_gnt",    32'({m1_gnt, m0_gnt}), 32'd0);
        check("rst_seq hold_rvalid", 32'(m0_rvalid), 32'd0);
        check("rst_seq hold_csb",    32'(sram_csb0), 32'd1);
        step("rst_seq2", 1'b0, IDLE, IDLE, win);
        step("rst_seq3", 1'b1, IDLE, IDLE, win);
        check("rst_seq post_rvalid", 32'(m0_rvalid), 32'd0);
        step("rst_seq4", 1'b1, rd(11'h010), rd(11'h011), win);
        check("rst_seq first_contention", 32'({m1_gnt, m0_gnt}), 32'b01);
        step("rst_seq5", 1'b1, IDLE, IDLE, win);

        // Randomized traffic: requesters mostly hold until granted, sometimes
        // withdraw, with occasional resets.
        r0 = IDLE;
        r1 = IDLE;
        win = -1;
        for (int i = 0; i < 500; i++) begin
            rs = ($urandom_range(0, 59) != 0);
            if (!(r0.req && win != 0 && $urandom_range(0, 7) != 0)) r0 = rnd_mst();
            if (!(r1.req && win != 1 && $urandom_range(0, 7) != 0)) r1 = rnd_mst();
            step($sformatf("rand%0d", i), rs, r0, r1, win);
        end
        step("rand_flush", 1'b1, IDLE, IDLE, win);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares the single read/write port (port 0) of the SoC SRAM bank between an instruction-fetch master (m0) and a data/load-store master (m1). It grants one request per cycle, drives the SRAM port 0 control, address and data lines, and routes the SRAM read data back to the requester that issued the access. The SRAM read latency is one cycle, so one response is in flight per cycle. The block sits between the core bus masters and `sram_wrapper` port 0.

## Interface
- `NUM_WMASKS`, 4, byte-enable width (DATA_WIDTH/8)
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 11, word-address width, same as wrapper `soc_addr0`
- `clk` in 1: single clock, also clocks SRAM port 0 externally
- `rst_n` in 1: reset, asynchronous and active-low
- `mX_req` in 1: request valid (X = 0, 1)
- `mX_gnt` out 1: request accepted this cycle
- `mX_we` in 1: 1 = write, 0 = read
- `mX_be` in NUM_WMASKS: byte enables for writes
- `mX_addr` in ADDR_WIDTH: word address
- `mX_wdata` in DATA_WIDTH: write data
- `mX_rvalid` out 1: response pulse, one cycle after grant
- `mX_rdata` out DATA_WIDTH: read data, valid while `mX_rvalid`
- `sram_csb0` out 1: chip select, active-low
- `sram_web0` out 1: write enable, active-low
- `sram_wmask0` out NUM_WMASKS: write mask
- `sram_addr0` out ADDR_WIDTH
- `sram_din0` out DATA_WIDTH
- `sram_dout0` in DATA_WIDTH: read data from wrapper

## Operation
- Requester holds `req`, `we`, `be`, `addr` and `wdata` stable until it sees `gnt`. `gnt` is combinational from `req` and the priority state.
- At most one `gnt` is asserted per cycle. A granted access drives `sram_csb0`=0, `sram_web0`=!we, and passes mask, addr and din from the winner.
- With no grant: `sram_csb0`=1, `sram_web0`=1, mask/addr/din=0.
- Priority is round-robin. The `last` flop records the last granted master. When both masters request, the master that is not `last` wins. A single requester always wins.
- Response register `rsp_vld`/`rsp_id`/`rsp_we` is loaded on every grant and cleared on cycles without a grant.
- `mX_rvalid` = `rsp_vld && rsp_id==X`. It pulses for both reads and writes.
- `mX_rdata` = `sram_dout0` for a read response. It is 0 for a write response or for no response to X.
- Back-to-back grants are allowed at 1 access/cycle. The response for grant N coincides with grant N+1.

## Timing
- Grant latency is 0 cycles. Response latency is exactly 1 cycle after the `gnt` cycle.
- Reset (`rst_n` low, asynchronous): `last`=m1, so m0 wins the first contention. `rsp_vld`=0. While `rst_n` is low, both `gnt`=0, `sram_csb0`=1, `sram_web0`=1, both `rvalid`=0 and both `rdata`=0.
- Reset asserted while a response is pending: the response is dropped. No `rvalid` is issued after reset releases.
- `req` is deasserted by a requester without a `gnt`: this is legal, and no access is issued.
- The `last` register updates only on a grant. Idle cycles preserve fairness state.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: the round-robin logic is removed and m0 always wins contention. The `last` flop is not instantiated.
- Not defined: round-robin as specified above (default).

## Structure
- Shared package `sram_pkg` holds:
  - the `DATA_WIDTH`/`ADDR_WIDTH`/`NUM_WMASKS` defaults;
  - `typedef enum logic {REQ_M0, REQ_M1} req_id_e`;
  - `typedef struct packed {we, be, addr, wdata} sram_req_t`.
- One sub-module, `rr_arb2`, is natural. It is a 2-way round-robin grant generator with `last` state and a fixed-priority fallback under the macro.
- Everything else is flat in `sram_port_arbiter`.

## Test plan
- Reset then idle, with no requests:
  - `sram_csb0`=1, both `gnt`=0, no `rvalid` over 10 cycles.
- Single read:
  - Preload word 0x005=0xDEADBEEF, then m0 reads addr 0x005.
  - Response: `m0_gnt` in cycle 0, `sram_csb0`=0/`web0`=1 in cycle 0, `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF in cycle 1, and `m1_rvalid`=0.
- Contention round-robin:
  - m0 and m1 both request continuously, with m0 reading 0x010 and m1 reading 0x011, for 4 cycles.
  - Grants m0, m1, m0, m1. Each `rvalid` follows its grant by 1 cycle with the matching data.
  - With `SRAM_ARB_FIXED_PRIO_EN` defined, m0 is granted in all 4 cycles.
- Byte-masked write then read:
  - m1 writes 0x7FF with `be`=0b0101 and `wdata`=0x11223344 over 0x00000000, then reads 0x7FF.
  - Response: `m1_rvalid` on the write with `m1_rdata`=0, then read data 0x00220044.
- Reset mid-response:
  - Assert `rst_n`=0 in the cycle after an m0 read grant.
  - `m0_rvalid` stays 0 during and after reset. The next contention is granted to m0.
- Withdrawn request:
  - m1 raises `req` while m0 is granted, then drops it before being granted.
  - No m1 access appears on the SRAM port and no `m1_rvalid` is issued.
